// File: rtl/minx16_bus_pkg.sv
// Shared types and constants for the Minx16 external-bus to Wishbone bridge.
// The MINX16_BUS_TIMEOUT_EN build option is handled in the bridge and watchdog files.
package minx16_bus_pkg;

    localparam int AD_W = 16;
    localparam int SEL_W = 2;
    localparam logic [AD_W-1:0] HIZ_ALL = 16'hFFFF;
    localparam logic [AD_W-1:0] ERR_RDATA_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_RD   = 3'd1,
        WB_WR   = 3'd2,
        HOLD_RD = 3'd3,
        HOLD_WR = 3'd4,
        DRAIN   = 3'd5
    } bus_state_e;

endpackage

// File: rtl/minx16_bus_watchdog.sv
// Ack watchdog for the bus bridge: counts un-acked Wishbone cycles and flags expiry.
// Only instantiated when MINX16_BUS_TIMEOUT_EN is defined.
module minx16_bus_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/minx16_bus_bridge.sv
// Demultiplexes the Minx16 AD bus and runs each CPU access as one classic Wishbone cycle.
// Define MINX16_BUS_TIMEOUT_EN to enable the ack timeout and the sticky err_o flag.
module minx16_bus_bridge
    import minx16_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter logic [AD_W-1:0] ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AD_W-1:0]  ad_i,
    output logic [AD_W-1:0]  ad_o,
    output logic [AD_W-1:0]  ad_e_o,
    input  logic             ale_i,
    input  logic             dle_i,
    input  logic [SEL_W-1:0] stb_i,
    input  logic             rd_i,
    input  logic             wr_i,
    output logic             rdy_o,
    output logic [AD_W-1:0]  wb_adr_o,
    output logic [AD_W-1:0]  wb_dat_o,
    input  logic [AD_W-1:0]  wb_dat_i,
    output logic [SEL_W-1:0] wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic             wb_ack_i,
    output logic             err_o
);

    bus_state_e       state_q, state_d;
    logic [AD_W-1:0]  addr_q, addr_d;
    logic [AD_W-1:0]  wdat_q, wdat_d;
    logic [AD_W-1:0]  rdata_q, rdata_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [AD_W-1:0]  ad_o_q, ad_o_d;
    logic [AD_W-1:0]  ad_e_q, ad_e_d;
    logic             rdy_q, rdy_d;
    logic             wb_active;
    logic             timeout_hit;

    assign wb_active = (state_q == WB_RD) || (state_q == WB_WR);

`ifdef MINX16_BUS_TIMEOUT_EN
    logic err_q;

    minx16_bus_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (!wb_active),
        .enable_i (wb_active && !wb_ack_i),
        .expired_o(timeout_hit)
    );

    // An ack arriving in the expiry cycle completes normally and leaves err_o alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (wb_active && !wb_ack_i && timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYC > 0);
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        ad_o_d  = '0;
        ad_e_d  = HIZ_ALL;
        rdy_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ale_i) begin
                    addr_d = ad_i;
                end
                if (rd_i) begin
                    sel_d = stb_i;
                    if (stb_i == '0) begin
                        rdata_d = ERR_RDATA;
                        state_d = HOLD_RD;
                    end else begin
                        state_d = WB_RD;
                    end
                end else if (wr_i && dle_i) begin
                    wdat_d = ad_i;
                    sel_d  = stb_i;
                    state_d = (stb_i == '0) ? HOLD_WR : WB_WR;
                end
            end
            WB_RD: begin
                if (wb_ack_i) begin
                    rdata_d = wb_dat_i;
                    state_d = rd_i ? HOLD_RD : DRAIN;
                end else if (timeout_hit) begin
                    rdata_d = ERR_RDATA;
                    state_d = rd_i ? HOLD_RD : DRAIN;
                end
            end
            WB_WR: begin
                if (wb_ack_i || timeout_hit) begin
                    state_d = wr_i ? HOLD_WR : DRAIN;
                end
            end
            HOLD_RD: begin
                // The pad is driven only while the core is still sampling with rd_i high.
                if (rd_i) begin
                    rdy_d  = 1'b1;
                    ad_e_d = '0;
                    ad_o_d = rdata_q;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD_WR: begin
                if (wr_i) begin
                    rdy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
            ad_o_q  <= '0;
            ad_e_q  <= HIZ_ALL;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
            ad_o_q  <= ad_o_d;
            ad_e_q  <= ad_e_d;
            rdy_q   <= rdy_d;
        end
    end

    assign ad_o     = ad_o_q;
    assign ad_e_o   = ad_e_q;
    assign rdy_o    = rdy_q;
    assign wb_cyc_o = wb_active;
    assign wb_stb_o = wb_active;
    assign wb_we_o  = (state_q == WB_WR);
    assign wb_adr_o = addr_q;
    assign wb_dat_o = wdat_q;
    assign wb_sel_o = sel_q;

endmodule

// File: tb/tb_minx16_bus_bridge.sv
// Scoreboard bench for minx16_bus_bridge: stimulus queues expected Wishbone and core
// responses, a negedge monitor pops and compares them when the DUT presents them.
module tb_minx16_bus_bridge;

    typedef struct {
        logic [15:0] adr;
        logic [1:0]  sel;
        logic        we;
        logic [15:0] dat;
    } wb_exp_t;

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
    } core_exp_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] ad_i = '0;
    logic [15:0] ad_o;
    logic [15:0] ad_e_o;
    logic        ale_i = 1'b0;
    logic        dle_i = 1'b0;
    logic [1:0]  stb_i = '0;
    logic        rd_i = 1'b0;
    logic        wr_i = 1'b0;
    logic        rdy_o;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i = '0;
    logic [1:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        err_o;

    int          n_assert = 0;
    int          n_fail = 0;
    int          ack_wait = 0;
    logic [15:0] slv_data = '0;

    wb_exp_t   wb_q[$];
    core_exp_t core_q[$];

    always #5 clk = ~clk;

    minx16_bus_bridge #(
        .TIMEOUT_CYC(8),
        .ERR_RDATA  (16'hFFFF)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .ad_i    (ad_i),
        .ad_o    (ad_o),
        .ad_e_o  (ad_e_o),
        .ale_i   (ale_i),
        .dle_i   (dle_i),
        .stb_i   (stb_i),
        .rd_i    (rd_i),
        .wr_i    (wr_i),
        .rdy_o   (rdy_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
        .wb_we_o (wb_we_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .err_o   (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [15:0] adr, input logic [1:0] sel,
                           input logic we, input logic [15:0] dat);
        wb_exp_t e;
        e.adr = adr;
        e.sel = sel;
        e.we  = we;
        e.dat = dat;
        wb_q.push_back(e);
    endtask

    task automatic push_core(input logic is_rd, input logic [15:0] data);
        core_exp_t e;
        e.is_rd = is_rd;
        e.data  = data;
        core_q.push_back(e);
    endtask

    task automatic latch_addr(input logic [15:0] addr);
        ale_i = 1'b1;
        ad_i  = addr;
        tick();
        ale_i = 1'b0;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (!rdy_o && lat < 30) begin
            tick();
            lat++;
        end
        check("rdy_seen", {31'b0, rdy_o}, 32'd1);
    endtask

    // Wishbone slave: acks after ack_wait wait states with slv_data.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            tick();
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
                if (wait_cnt >= ack_wait) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = slv_data;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wb_ack_i = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: pop and compare on each new Wishbone cycle and each rdy assertion.
    initial begin
        logic prev_cyc;
        logic prev_rdy;
        wb_exp_t we_e;
        core_exp_t ce;
        prev_cyc = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_cyc_o && !prev_cyc) begin
                if (wb_q.size() == 0) begin
                    check("wb_unexpected_cycle", 32'(wb_q.size()), 32'd1);
                end else begin
                    we_e = wb_q.pop_front();
                    check("wb_adr", {16'b0, wb_adr_o}, {16'b0, we_e.adr});
                    check("wb_sel", {30'b0, wb_sel_o}, {30'b0, we_e.sel});
                    check("wb_we", {31'b0, wb_we_o}, {31'b0, we_e.we});
                    check("wb_stb", {31'b0, wb_stb_o}, 32'd1);
                    if (we_e.we) check("wb_dat", {16'b0, wb_dat_o}, {16'b0, we_e.dat});
                    $display("WB  cycle adr=%h sel=%b we=%b", wb_adr_o, wb_sel_o, wb_we_o);
                end
            end
            if (rdy_o && !prev_rdy) begin
                if (core_q.size() == 0) begin
                    check("core_unexpected_rdy", 32'(core_q.size()), 32'd1);
                end else begin
                    ce = core_q.pop_front();
                    if (ce.is_rd) begin
                        check("rd_ad_o", {16'b0, ad_o}, {16'b0, ce.data});
                        check("rd_ad_e", {16'b0, ad_e_o}, 32'h0000);
                    end else begin
                        check("wr_ad_e", {16'b0, ad_e_o}, 32'hFFFF);
                    end
                    $display("CORE rdy rd=%b ad_o=%h ad_e=%h", ce.is_rd, ad_o, ad_e_o);
                end
            end
            prev_cyc = wb_cyc_o;
            prev_rdy = rdy_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int cnt;
        logic seen;

        // Reset state
        tick();
        tick();
        check("rst_rdy", {31'b0, rdy_o}, 32'd0);
        check("rst_ad_e", {16'b0, ad_e_o}, 32'hFFFF);
        check("rst_ad_o", {16'b0, ad_o}, 32'h0);
        check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("rst_adr", {16'b0, wb_adr_o}, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        rst_i = 1'b1;
        tick();

        // Basic read, zero wait states
        latch_addr(16'h1234);
        rd_i = 1'b1; stb_i = 2'b11; slv_data = 16'hBEEF; ack_wait = 0;
        push_wb(16'h1234, 2'b11, 1'b0, 16'h0);
        push_core(1'b1, 16'hBEEF);
        wait_rdy(lat);
        check("rd_latency", 32'(lat), 32'd3);
        tick(); tick();
        check("rd_hold_rdy", {31'b0, rdy_o}, 32'd1);
        check("rd_hold_ad_o", {16'b0, ad_o}, 32'hBEEF);
        rd_i = 1'b0;
        tick();
        check("rd_end_ad_e", {16'b0, ad_e_o}, 32'hFFFF);
        check("rd_end_rdy", {31'b0, rdy_o}, 32'd0);
        tick();

        // Write: wr without dle must wait, then 3 wait states
        latch_addr(16'h00A0);
        wr_i = 1'b1; dle_i = 1'b0; stb_i = 2'b10; ad_i = 16'h5A5A; ack_wait = 3;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | wb_cyc_o;
        end
        check("wr_no_dle_idle", {31'b0, seen}, 32'd0);
        push_wb(16'h00A0, 2'b10, 1'b1, 16'h5A5A);
        push_core(1'b0, 16'h0);
        dle_i = 1'b1;
        wait_rdy(lat);
        check("wr_latency", 32'(lat), 32'd6);
        tick(); tick();
        check("wr_hold_rdy", {31'b0, rdy_o}, 32'd1);
        wr_i = 1'b0; dle_i = 1'b0;
        tick();
        check("wr_end_rdy", {31'b0, rdy_o}, 32'd0);
        tick();

        // Abort: rd withdrawn before the ack
        latch_addr(16'h0300);
        rd_i = 1'b1; stb_i = 2'b01; ack_wait = 4; slv_data = 16'h1111;
        push_wb(16'h0300, 2'b01, 1'b0, 16'h0);
        tick(); tick();
        rd_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | rdy_o | (ad_e_o != 16'hFFFF);
        end
        check("abort_no_rdy_no_drive", {31'b0, seen}, 32'd0);
        check("abort_idle_cyc", {31'b0, wb_cyc_o}, 32'd0);

        // Zero strobes: no Wishbone cycle, error data returned
        latch_addr(16'h0040);
        rd_i = 1'b1; stb_i = 2'b00; ack_wait = 0;
        push_core(1'b1, 16'hFFFF);
        wait_rdy(lat);
        check("zs_latency", 32'(lat), 32'd2);
        rd_i = 1'b0;
        tick(); tick();

        // Read has priority over a simultaneous write
        latch_addr(16'h2222);
        rd_i = 1'b1; wr_i = 1'b1; dle_i = 1'b1; stb_i = 2'b11; ad_i = 16'h9999;
        slv_data = 16'h1357;
        push_wb(16'h2222, 2'b11, 1'b0, 16'h0);
        push_core(1'b1, 16'h1357);
        wait_rdy(lat);
        rd_i = 1'b0; wr_i = 1'b0; dle_i = 1'b0;
        tick(); tick();

`ifdef MINX16_BUS_TIMEOUT_EN
        // Ack in the expiry cycle wins
        latch_addr(16'h0700);
        rd_i = 1'b1; stb_i = 2'b11; ack_wait = 7; slv_data = 16'h4242;
        push_wb(16'h0700, 2'b11, 1'b0, 16'h0);
        push_core(1'b1, 16'h4242);
        wait_rdy(lat);
        check("ack_at_expiry_err", {31'b0, err_o}, 32'd0);
        rd_i = 1'b0;
        tick(); tick();

        // Missing ack times out after 8 cycles
        latch_addr(16'h0600);
        rd_i = 1'b1; stb_i = 2'b11; ack_wait = 1000;
        push_wb(16'h0600, 2'b11, 1'b0, 16'h0);
        push_core(1'b1, 16'hFFFF);
        tick();
        cnt = 0;
        while (wb_cyc_o && cnt < 50) begin
            cnt++;
            tick();
        end
        check("timeout_cyc_len", 32'(cnt), 32'd8);
        check("timeout_err", {31'b0, err_o}, 32'd1);
        wait_rdy(lat);
        rd_i = 1'b0;
        tick(); tick();
        check("err_sticky", {31'b0, err_o}, 32'd1);
`endif

        // Reset in the middle of a Wishbone cycle
        latch_addr(16'h0500);
        rd_i = 1'b1; stb_i = 2'b11; ack_wait = 1000;
        push_wb(16'h0500, 2'b11, 1'b0, 16'h0);
        tick(); tick();
        check("pre_rst_cyc", {31'b0, wb_cyc_o}, 32'd1);
        rst_i = 1'b0;
        tick();
        check("mid_rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        check("mid_rst_stb", {31'b0, wb_stb_o}, 32'd0);
        check("mid_rst_rdy", {31'b0, rdy_o}, 32'd0);
        check("mid_rst_ad_e", {16'b0, ad_e_o}, 32'hFFFF);
        check("mid_rst_err", {31'b0, err_o}, 32'd0);
        rst_i = 1'b1; rd_i = 1'b0; ack_wait = 0;
        for (int i = 0; i < 5; i++) tick();

        check("wb_q_drained", 32'(wb_q.size()), 32'd0);
        check("core_q_drained", 32'(core_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
